mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have these parameters, one per line (name, default, meaning):
  TIMEOUT  255  cycles without dmemAck before a bus-timeout exception.
REQ-002 SHALL have these ports, one per line (name, direction, width, meaning):
  clk              in   1   single clock; all state changes on rising edge.
  reset            in   1   synchronous, active-high reset.
  memValid         in   1   MEM stage register holds a live instruction.
  memFlush         in   1   kill the MEM instruction (branch/exception redirect).
  memNewPC         in   32  PC+4 from the MEM stage register.
  memInstruction   in   32  instruction from the MEM stage register.
  memAluOut        in   32  effective address or ALU result.
  memMemWriteData  in   32  store data, unshifted.
  memWriteReg      in   5   destination register.
  memStall         out  1   freeze PC and all upstream stage registers.
  dmemReq          out  1   data-bus request; held until acknowledged.
  dmemWe           out  1   1 = store.
  dmemAddr         out  32  word-aligned address ({memAluOut[31:2],2'b00}).
  dmemByteEn       out  4   byte-lane enables.
  dmemWData        out  32  lane-shifted store data.
  dmemRData        in   32  read data; valid when dmemAck=1.
  dmemAck          in   1   transfer complete this cycle.
  wbValid          out  1   WB register holds a live instruction.
  wbNewPC          out  32  registered memNewPC.
  wbInstruction    out  32  registered memInstruction.
  wbAluOut         out  32  registered memAluOut.
  wbMemData        out  32  extended load result; 0 for non-loads.
  wbWriteReg       out  5   destination; forced to 0 on exception.
  wbExcept         out  2   00 none, 01 misaligned, 10 bus timeout.

Function
REQ-003 SHALL decode opcode memInstruction[31:26]: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B; all other opcodes are non-memory.
REQ-004 SHALL pass a non-memory instruction to the WB outputs with a latency of 1 cycle, never asserting memStall.
REQ-005 SHALL treat an access as misaligned when the halfword address[0]=1 or the word address[1:0]≠0, and then: issue no request; next cycle wbValid=1, wbExcept=01, wbWriteReg=0; no stall.
REQ-006 SHALL use an FSM with states IDLE and WAIT.
  IDLE: an aligned memory op with memValid=1 and memFlush=0 asserts dmemReq the same cycle (combinational).
  IDLE, dmemAck=1 in that same cycle: completes; stays IDLE.
  IDLE, otherwise: moves to WAIT.
REQ-007 SHALL in WAIT hold dmemReq and all dmem* outputs stable until dmemAck=1, then return to IDLE and load the WB outputs at that edge.
REQ-008 SHALL drive memStall = op requested AND NOT (dmemAck OR timeout) in the current cycle, so upstream advances on the completing cycle only.
REQ-009 SHALL set byte enables and write data as follows:
  byte: dmemByteEn = 1<<addr[1:0]; data replicated to all 4 lanes.
  half: dmemByteEn = 0011 or 1100 by addr[1]; data replicated to both halves.
  word: dmemByteEn = 1111.
REQ-010 SHALL select the load lane by addr[1:0] and extend it: LB/LH sign-extend, LBU/LHU zero-extend; stores give wbMemData=0.
REQ-011 SHALL count cycles in WAIT with an 8-bit counter; when it reaches TIMEOUT without an ack:
  drop dmemReq, return to IDLE, release the stall;
  next cycle: wbValid=1, wbExcept=10, wbWriteReg=0.
REQ-012 SHALL handle memFlush as follows:
  in IDLE: kills the op, with no request and wbValid=0 next cycle;
  in WAIT: the transfer continues to ack or timeout, and the result is discarded (wbValid=0).
REQ-013 SHALL ignore dmemAck while dmemReq=0.
REQ-014 SHALL load wbValid=0 at every edge where no instruction completes.

Reset
REQ-015 SHALL, on reset=1 at a rising edge:
  force IDLE and clear the counter;
  set all wb* outputs to 0;
  deassert dmemReq and memStall the next cycle, including mid-WAIT; a late ack is then ignored per REQ-013.

Structure
REQ-016 SHALL take opcode constants, the WORD/REG widths and the wbExcept encodings from the shared ISA definitions include, adding the load/store opcodes there.
REQ-017 SHALL contain one sub-module, load_extend, which is combinational and performs lane select and extension.

Verification
REQ-018 SHALL cover these directed scenarios:
  ADDU, memValid=1 -> next cycle wbValid=1, wbAluOut=memAluOut, memStall never high.
  LB at 0x1003, dmemRData=0x80FFFFFF, ack after 3 cycles -> dmemByteEn=1000, memStall high 3 cycles, wbMemData=0xFFFFFF80.
  SH at 0x0002, data 0x1234ABCD, immediate ack -> dmemWe=1, dmemByteEn=1100, dmemWData=0xABCDABCD, no stall.
  LW at 0x0006 -> no dmemReq, next cycle wbExcept=01, wbWriteReg=0.
  LW with ack withheld -> dmemReq drops after 255 WAIT cycles, wbExcept=10; reset asserted mid-WAIT instead -> dmemReq=0 next cycle, all wb*=0.
  LHU with memFlush=1 in WAIT, ack=0xFFFF8001 -> wbValid stays 0.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared ISA definitions for the MEM stage: widths, load/store opcodes, exception codes and the
// memory-op decoder.
package mem_access_stage_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned RegW  = 5;

  localparam logic [5:0] OpLb  = 6'h20;
  localparam logic [5:0] OpLh  = 6'h21;
  localparam logic [5:0] OpLw  = 6'h23;
  localparam logic [5:0] OpLbu = 6'h24;
  localparam logic [5:0] OpLhu = 6'h25;
  localparam logic [5:0] OpSb  = 6'h28;
  localparam logic [5:0] OpSh  = 6'h29;
  localparam logic [5:0] OpSw  = 6'h2B;

  typedef enum logic [1:0] {
    ExcNone       = 2'b00,
    ExcMisaligned = 2'b01,
    ExcBusTimeout = 2'b10
  } except_e;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10
  } size_e;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } state_e;

  typedef struct packed {
    logic  is_load;
    logic  is_store;
    size_e size;
    logic  sign_ext;
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [5:0] opcode);
    mem_op_t op;
    op.is_load  = 1'b0;
    op.is_store = 1'b0;
    op.size     = SzWord;
    op.sign_ext = 1'b0;
    case (opcode)
      OpLb:    begin op.is_load = 1'b1;  op.size = SzByte; op.sign_ext = 1'b1; end
      OpLh:    begin op.is_load = 1'b1;  op.size = SzHalf; op.sign_ext = 1'b1; end
      OpLw:    begin op.is_load = 1'b1;  op.size = SzWord; end
      OpLbu:   begin op.is_load = 1'b1;  op.size = SzByte; end
      OpLhu:   begin op.is_load = 1'b1;  op.size = SzHalf; end
      OpSb:    begin op.is_store = 1'b1; op.size = SzByte; end
      OpSh:    begin op.is_store = 1'b1; op.size = SzHalf; end
      OpSw:    begin op.is_store = 1'b1; op.size = SzWord; end
      default: ;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword lane out of the read word and sign- or zero-extends it.
module load_extend
  import mem_access_stage_pkg::*;
(
  input  logic [WordW-1:0] rdata,
  input  logic [1:0]       lane,
  input  size_e            size,
  input  logic             sign_ext,
  output logic [WordW-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (lane)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (size)
      SzByte:  data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SzHalf:  data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-bus loads/stores, stalls upstream while waiting for an ack,
// flags misaligned and timed-out accesses, and loads the WB stage register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memValid,
  input  logic             memFlush,
  input  logic [WordW-1:0] memNewPC,
  input  logic [WordW-1:0] memInstruction,
  input  logic [WordW-1:0] memAluOut,
  input  logic [WordW-1:0] memMemWriteData,
  input  logic [RegW-1:0]  memWriteReg,
  output logic             memStall,
  output logic             dmemReq,
  output logic             dmemWe,
  output logic [WordW-1:0] dmemAddr,
  output logic [3:0]       dmemByteEn,
  output logic [WordW-1:0] dmemWData,
  input  logic [WordW-1:0] dmemRData,
  input  logic             dmemAck,
  output logic             wbValid,
  output logic [WordW-1:0] wbNewPC,
  output logic [WordW-1:0] wbInstruction,
  output logic [WordW-1:0] wbAluOut,
  output logic [WordW-1:0] wbMemData,
  output logic [RegW-1:0]  wbWriteReg,
  output logic [1:0]       wbExcept
);

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT - 1);

  state_e           state_q;
  logic [7:0]       cnt_q;
  logic             kill_q;
  logic [WordW-1:0] pc_q, instr_q, alu_q, sdata_q;
  logic [RegW-1:0]  wreg_q;

  logic             wb_valid_q;
  logic [WordW-1:0] wb_pc_q, wb_instr_q, wb_alu_q, wb_mdata_q;
  logic [RegW-1:0]  wb_wreg_q;
  except_e          wb_except_q;

  logic             in_wait;
  logic [WordW-1:0] src_pc, src_instr, src_alu, src_sdata;
  logic [RegW-1:0]  src_wreg;
  mem_op_t          op;
  logic             is_mem, misaligned, live_idle, req, timeout;
  logic             pass_idle, done_ack, done_to, finish, discard;
  except_e          exc;
  logic [3:0]       be;
  logic [WordW-1:0] wdata, load_data;

  assign in_wait = (state_q == StWait);

  // While waiting, everything comes from the copy taken at issue so the bus stays stable even if
  // the MEM register is flushed underneath us.
  always_comb begin
    if (in_wait) begin
      src_pc    = pc_q;
      src_instr = instr_q;
      src_alu   = alu_q;
      src_sdata = sdata_q;
      src_wreg  = wreg_q;
    end else begin
      src_pc    = memNewPC;
      src_instr = memInstruction;
      src_alu   = memAluOut;
      src_sdata = memMemWriteData;
      src_wreg  = memWriteReg;
    end
  end

  assign op         = decode_op(src_instr[31:26]);
  assign is_mem     = op.is_load | op.is_store;
  assign misaligned = is_mem & (((op.size == SzHalf) & src_alu[0]) |
                                ((op.size == SzWord) & (src_alu[1:0] != 2'b00)));
  assign live_idle  = ~in_wait & memValid & ~memFlush;
  assign req        = in_wait | (live_idle & is_mem & ~misaligned);
  assign timeout    = in_wait & (cnt_q == TimeoutLim);

  assign pass_idle = live_idle & ~(is_mem & ~misaligned);
  assign done_ack  = req & dmemAck;
  assign done_to   = timeout & ~dmemAck;
  assign finish    = pass_idle | done_ack | done_to;
  assign discard   = in_wait & (kill_q | memFlush);

  always_comb begin
    exc = ExcNone;
    if (pass_idle && misaligned) begin
      exc = ExcMisaligned;
    end else if (done_to) begin
      exc = ExcBusTimeout;
    end
  end

  always_comb begin
    be    = 4'b1111;
    wdata = src_sdata;
    case (op.size)
      SzByte: begin
        be    = 4'b0001 << src_alu[1:0];
        wdata = {4{src_sdata[7:0]}};
      end
      SzHalf: begin
        be    = src_alu[1] ? 4'b1100 : 4'b0011;
        wdata = {2{src_sdata[15:0]}};
      end
      default: ;
    endcase
  end

  load_extend u_load_extend (
    .rdata    (dmemRData),
    .lane     (src_alu[1:0]),
    .size     (op.size),
    .sign_ext (op.sign_ext),
    .data     (load_data)
  );

  assign memStall   = req & ~(dmemAck | timeout);
  assign dmemReq    = req;
  assign dmemWe     = req & op.is_store;
  assign dmemAddr   = {src_alu[31:2], 2'b00};
  assign dmemByteEn = req ? be : 4'b0000;
  assign dmemWData  = wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      pc_q        <= '0;
      instr_q     <= '0;
      alu_q       <= '0;
      sdata_q     <= '0;
      wreg_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_pc_q     <= '0;
      wb_instr_q  <= '0;
      wb_alu_q    <= '0;
      wb_mdata_q  <= '0;
      wb_wreg_q   <= '0;
      wb_except_q <= ExcNone;
    end else begin
      wb_valid_q <= finish & ~discard;
      if (finish) begin
        wb_pc_q     <= src_pc;
        wb_instr_q  <= src_instr;
        wb_alu_q    <= src_alu;
        wb_mdata_q  <= (done_ack && op.is_load) ? load_data : '0;
        wb_wreg_q   <= (exc == ExcNone) ? src_wreg : '0;
        wb_except_q <= exc;
      end

      unique case (state_q)
        StIdle: begin
          if (req && !dmemAck) begin
            state_q <= StWait;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            pc_q    <= memNewPC;
            instr_q <= memInstruction;
            alu_q   <= memAluOut;
            sdata_q <= memMemWriteData;
            wreg_q  <= memWriteReg;
          end
        end
        StWait: begin
          if (dmemAck || timeout) begin
            state_q <= StIdle;
          end else begin
            cnt_q  <= cnt_q + 8'd1;
            kill_q <= kill_q | memFlush;
          end
        end
      endcase
    end
  end

  assign wbValid       = wb_valid_q;
  assign wbNewPC       = wb_pc_q;
  assign wbInstruction = wb_instr_q;
  assign wbAluOut      = wb_alu_q;
  assign wbMemData     = wb_mdata_q;
  assign wbWriteReg    = wb_wreg_q;
  assign wbExcept      = wb_except_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; expected WB results are queued at issue and popped when
// the stage register is loaded.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        memValid, memFlush;
  logic [31:0] memNewPC, memInstruction, memAluOut, memMemWriteData;
  logic [4:0]  memWriteReg;
  logic        memStall, dmemReq, dmemWe;
  logic [31:0] dmemAddr, dmemWData, dmemRData;
  logic [3:0]  dmemByteEn;
  logic        dmemAck;
  logic        wbValid;
  logic [31:0] wbNewPC, wbInstruction, wbAluOut, wbMemData;
  logic [4:0]  wbWriteReg;
  logic [1:0]  wbExcept;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] mdata;
    logic [4:0]  wreg;
    logic [1:0]  exc;
  } wb_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [31:0] mdata;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [4:0]  wreg;
  } vec_t;

  wb_t sb[$];
  int  checks = 0;
  int  fails  = 0;

  mem_access_stage #(.TIMEOUT(255)) dut (
    .clk             (clk),
    .reset           (reset),
    .memValid        (memValid),
    .memFlush        (memFlush),
    .memNewPC        (memNewPC),
    .memInstruction  (memInstruction),
    .memAluOut       (memAluOut),
    .memMemWriteData (memMemWriteData),
    .memWriteReg     (memWriteReg),
    .memStall        (memStall),
    .dmemReq         (dmemReq),
    .dmemWe          (dmemWe),
    .dmemAddr        (dmemAddr),
    .dmemByteEn      (dmemByteEn),
    .dmemWData       (dmemWData),
    .dmemRData       (dmemRData),
    .dmemAck         (dmemAck),
    .wbValid         (wbValid),
    .wbNewPC         (wbNewPC),
    .wbInstruction   (wbInstruction),
    .wbAluOut        (wbAluOut),
    .wbMemData       (wbMemData),
    .wbWriteReg      (wbWriteReg),
    .wbExcept        (wbExcept)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 5'd1, 5'd4, 16'h0000};
  endfunction

  function automatic wb_t act_wb();
    return {wbValid, wbNewPC, wbInstruction, wbAluOut, wbMemData, wbWriteReg, wbExcept};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [31:0] instr,
                       input logic [31:0] alu, input logic [31:0] sdata,
                       input logic [4:0] wreg, input logic [31:0] pc);
    memValid        = v;
    memFlush        = f;
    memInstruction  = instr;
    memAluOut       = alu;
    memMemWriteData = sdata;
    memWriteReg     = wreg;
    memNewPC        = pc;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    dmemAck = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_in();
    dmemRData = 32'h0;
    step();
    step();
    checks++;
    if (act_wb() !== wb_t'(0))
      $display("FAIL reset_wb: got %h want 0", act_wb());
    if (act_wb() !== wb_t'(0)) fails++;
    checks++;
    if (dmemReq !== 1'b0 || memStall !== 1'b0) begin
      fails++;
      $display("FAIL reset_bus: req=%b stall=%b want 0 0", dmemReq, memStall);
    end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    wb_t exp;
    drive(1'b1, 1'b0, 32'h0022_1821, 32'h1234_5678, 32'h0, 5'd3, 32'h0000_0104);
    #1;
    checks++;
    if (memStall !== 1'b0 || dmemReq !== 1'b0) begin
      fails++;
      $display("FAIL alu_bus: stall=%b req=%b want 0 0", memStall, dmemReq);
    end
    sb.push_back({1'b1, 32'h0000_0104, 32'h0022_1821, 32'h1234_5678, 32'h0, 5'd3, 2'b00});
    step();
    idle_in();
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL alu_wb: scoreboard empty");
    end else begin
      exp = sb.pop_front();
      if (act_wb() !== exp) begin
        fails++;
        $display("FAIL alu_wb: got %h want %h", act_wb(), exp);
      end
    end
    step();
    checks++;
    if (wbValid !== 1'b0) begin
      fails++;
      $display("FAIL alu_bubble: wbValid=%b want 0", wbValid);
    end
  endtask

  task automatic test_lb_wait();
    wb_t exp;
    int  stalls = 0;
    drive(1'b1, 1'b0, mk(6'h20), 32'h0000_1003, 32'h0, 5'd4, 32'h0000_0200);
    dmemRData = 32'h80FF_FFFF;
    for (int i = 0; i < 4; i++) begin
      dmemAck = (i == 3);
      #1;
      checks++;
      if (dmemReq !== 1'b1 || dmemByteEn !== 4'b1000 || dmemAddr !== 32'h0000_1000 ||
          dmemWe !== 1'b0) begin
        fails++;
        $display("FAIL lb_bus[%0d]: req=%b be=%b addr=%h we=%b want 1 1000 00001000 0",
                 i, dmemReq, dmemByteEn, dmemAddr, dmemWe);
      end
      if (memStall === 1'b1) stalls++;
      step();
    end
    idle_in();
    sb.push_back({1'b1, 32'h0000_0200, mk(6'h20), 32'h0000_1003, 32'hFFFF_FF80, 5'd4, 2'b00});
    checks++;
    if (stalls != 3) begin
      fails++;
      $display("FAIL lb_stall: stall cycles %0d want 3", stalls);
    end
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL lb_wb: scoreboard empty");
    end else begin
      exp = sb.pop_front();
      if (act_wb() !== exp) begin
        fails++;
        $display("FAIL lb_wb: got %h want %h", act_wb(), exp);
      end
    end
  endtask

  task automatic test_sh();
    wb_t exp;
    drive(1'b1, 1'b0, mk(6'h29), 32'h0000_0002, 32'h1234_ABCD, 5'd0, 32'h0000_0300);
    dmemAck = 1'b1;
    #1;
    checks++;
    if (dmemReq !== 1'b1 || dmemWe !== 1'b1 || dmemByteEn !== 4'b1100 ||
        dmemWData !== 32'hABCD_ABCD || memStall !== 1'b0) begin
      fails++;
      $display("FAIL sh_bus: req=%b we=%b be=%b wdata=%h stall=%b want 1 1 1100 abcdabcd 0",
               dmemReq, dmemWe, dmemByteEn, dmemWData, memStall);
    end
    sb.push_back({1'b1, 32'h0000_0300, mk(6'h29), 32'h0000_0002, 32'h0, 5'd0, 2'b00});
    step();
    idle_in();
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sh_wb: scoreboard empty");
    end else begin
      exp = sb.pop_front();
      if (act_wb() !== exp) begin
        fails++;
        $display("FAIL sh_wb: got %h want %h", act_wb(), exp);
      end
    end
  endtask

  task automatic test_misaligned();
    wb_t exp;
    logic [5:0]  ops[2]  = '{6'h23, 6'h21};
    logic [31:0] adrs[2] = '{32'h0000_0006, 32'h0000_0001};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, mk(ops[i]), adrs[i], 32'h0, 5'd9, 32'h0000_0500);
      #1;
      checks++;
      if (dmemReq !== 1'b0 || memStall !== 1'b0) begin
        fails++;
        $display("FAIL misaligned_bus[%0d]: req=%b stall=%b want 0 0", i, dmemReq, memStall);
      end
      sb.push_back({1'b1, 32'h0000_0500, mk(ops[i]), adrs[i], 32'h0, 5'd0, 2'b01});
      step();
      idle_in();
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL misaligned_wb[%0d]: scoreboard empty", i);
      end else begin
        exp = sb.pop_front();
        if (act_wb() !== exp) begin
          fails++;
          $display("FAIL misaligned_wb[%0d]: got %h want %h", i, act_wb(), exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t        tbl[8];
    wb_t         exp;
    logic        is_st;
    logic [31:0] pc;
    tbl[0] = '{6'h23, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 4'b1111, 5'd5};
    tbl[1] = '{6'h24, 32'h0000_1001, 32'h0, 32'h1122_8344, 32'h0000_0083, 32'h0, 4'b0010, 5'd6};
    tbl[2] = '{6'h21, 32'h0000_2002, 32'h0, 32'h8001_1234, 32'hFFFF_8001, 32'h0, 4'b1100, 5'd7};
    tbl[3] = '{6'h25, 32'h0000_0006, 32'h0, 32'h8001_0000, 32'h0000_8001, 32'h0, 4'b1100, 5'd8};
    tbl[4] = '{6'h20, 32'h0000_0000, 32'h0, 32'h0000_007F, 32'h0000_007F, 32'h0, 4'b0001, 5'd9};
    tbl[5] = '{6'h28, 32'h0000_0101, 32'h0000_00A5, 32'h0, 32'h0, 32'hA5A5_A5A5, 4'b0010, 5'd0};
    tbl[6] = '{6'h2B, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 32'h0, 32'hCAFE_F00D, 4'b1111, 5'd0};
    tbl[7] = '{6'h21, 32'h0000_0000, 32'h0, 32'h0000_7FFF, 32'h0000_7FFF, 32'h0, 4'b0011, 5'd10};
    for (int i = 0; i < 8; i++) begin
      pc = 32'h0000_0400 + 32'(4 * i);
      drive(1'b1, 1'b0, mk(tbl[i].op), tbl[i].alu, tbl[i].sdata, tbl[i].wreg, pc);
      dmemRData = tbl[i].rdata;
      dmemAck   = 1'b1;
      is_st     = tbl[i].op[3];
      #1;
      checks++;
      if (dmemReq !== 1'b1 || memStall !== 1'b0 || dmemByteEn !== tbl[i].be ||
          dmemWe !== is_st || (is_st && dmemWData !== tbl[i].wdata)) begin
        fails++;
        $display("FAIL b2b_bus[%0d]: req=%b stall=%b be=%b we=%b wdata=%h want 1 0 %b %b %h",
                 i, dmemReq, memStall, dmemByteEn, dmemWe, dmemWData, tbl[i].be, is_st,
                 tbl[i].wdata);
      end
      sb.push_back({1'b1, pc, mk(tbl[i].op), tbl[i].alu, tbl[i].mdata, tbl[i].wreg, 2'b00});
      step();
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL b2b_wb[%0d]: scoreboard empty", i);
      end else begin
        exp = sb.pop_front();
        if (act_wb() !== exp) begin
          fails++;
          $display("FAIL b2b_wb[%0d]: got %h want %h", i, act_wb(), exp);
        end
      end
    end
    idle_in();
  endtask

  task automatic test_flush();
    // Flush while waiting: transfer completes but result is dropped.
    drive(1'b1, 1'b0, mk(6'h25), 32'h0000_0010, 32'h0, 5'd11, 32'h0000_0600);
    #1;
    checks++;
    if (dmemReq !== 1'b1) begin
      fails++;
      $display("FAIL flush_wait_req: req=%b want 1", dmemReq);
    end
    step();
    memFlush = 1'b1;
    step();
    memFlush  = 1'b0;
    dmemAck   = 1'b1;
    dmemRData = 32'hFFFF_8001;
    #1;
    checks++;
    if (memStall !== 1'b0 || dmemReq !== 1'b1) begin
      fails++;
      $display("FAIL flush_wait_ack: stall=%b req=%b want 0 1", memStall, dmemReq);
    end
    step();
    idle_in();
    checks++;
    if (wbValid !== 1'b0) begin
      fails++;
      $display("FAIL flush_wait_wb: wbValid=%b want 0", wbValid);
    end
    // Flush in IDLE: no request at all.
    drive(1'b1, 1'b1, mk(6'h23), 32'h0000_0020, 32'h0, 5'd12, 32'h0000_0700);
    #1;
    checks++;
    if (dmemReq !== 1'b0 || memStall !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle_bus: req=%b stall=%b want 0 0", dmemReq, memStall);
    end
    step();
    idle_in();
    checks++;
    if (wbValid !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle_wb: wbValid=%b want 0", wbValid);
    end
  endtask

  task automatic test_timeout();
    wb_t exp;
    int  stalls = 0;
    bit  hit = 0;
    drive(1'b1, 1'b0, mk(6'h23), 32'h0000_0040, 32'h0, 5'd13, 32'h0000_0800);
    dmemAck = 1'b0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (memStall !== 1'b1) begin
        hit = 1;
        break;
      end
      stalls++;
      step();
    end
    checks++;
    if (!hit || stalls != 255) begin
      fails++;
      $display("FAIL timeout_len: stall cycles %0d (released=%0d) want 255", stalls, hit);
    end
    sb.push_back({1'b1, 32'h0000_0800, mk(6'h23), 32'h0000_0040, 32'h0, 5'd0, 2'b10});
    step();
    idle_in();
    #1;
    checks++;
    if (dmemReq !== 1'b0) begin
      fails++;
      $display("FAIL timeout_req: req=%b want 0", dmemReq);
    end
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL timeout_wb: scoreboard empty");
    end else begin
      exp = sb.pop_front();
      if (act_wb() !== exp) begin
        fails++;
        $display("FAIL timeout_wb: got %h want %h", act_wb(), exp);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b1, 1'b0, mk(6'h23), 32'h0000_0080, 32'h0, 5'd14, 32'h0000_0900);
    dmemAck = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (dmemReq !== 1'b1 || memStall !== 1'b1) begin
      fails++;
      $display("FAIL rstwait_pre: req=%b stall=%b want 1 1", dmemReq, memStall);
    end
    reset = 1'b1;
    idle_in();
    step();
    reset = 1'b0;
    checks++;
    if (dmemReq !== 1'b0 || memStall !== 1'b0) begin
      fails++;
      $display("FAIL rstwait_bus: req=%b stall=%b want 0 0", dmemReq, memStall);
    end
    checks++;
    if (act_wb() !== wb_t'(0)) begin
      fails++;
      $display("FAIL rstwait_wb: got %h want 0", act_wb());
    end
    dmemAck   = 1'b1;
    dmemRData = 32'h1234_5678;
    #1;
    checks++;
    if (dmemReq !== 1'b0 || memStall !== 1'b0) begin
      fails++;
      $display("FAIL late_ack_bus: req=%b stall=%b want 0 0", dmemReq, memStall);
    end
    step();
    dmemAck = 1'b0;
    checks++;
    if (wbValid !== 1'b0) begin
      fails++;
      $display("FAIL late_ack_wb: wbValid=%b want 0", wbValid);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_wait();
    test_sh();
    test_misaligned();
    test_back_to_back();
    test_flush();
    test_timeout();
    test_reset_mid_wait();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
